phase_readout_ctrl: RTL and testbench

- Measurement sequencer for the multi-phase readout array (PHASE_WIDTH-bit per-phase detector vector).
- On a start request it:
  - enables the phase front-end;
  - waits a programmable settle time;
  - samples the phase vector 2^k times;
  - encodes each thermometer sample to a phase count and accumulates the counts.
- Returns a fixed-point averaged phase plus a bubble-error flag over a valid/ready handshake.
- Sits between the phase readout array and the host/wishbone register block.

---
 rtl/phase_readout_pkg.sv | 18 +
 rtl/phase_therm_enc.sv | 26 ++
 rtl/phase_readout_ctrl.sv | 133 +++++++++++++
 tb/tb_phase_readout_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_readout_pkg.sv
// Shared types and default sizing for the phase readout sequencer.
package phase_readout_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_PHASE_WIDTH  = 11;
  localparam int DEF_CODE_W       = 4;
  localparam int DEF_AVG_MAX_LOG2 = 4;
  localparam int DEF_ACC_W        = DEF_CODE_W + DEF_AVG_MAX_LOG2;
  localparam int DEF_SETTLE_W     = 8;

endpackage

// File: rtl/phase_therm_enc.sv
// Thermometer-to-count encoder: popcount plus a check that the ones are
// contiguous from the LSB (all-zero counts as a clean code).
module phase_therm_enc
  import phase_readout_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int CODE_W      = DEF_CODE_W
) (
  input  logic [PHASE_WIDTH-1:0] sample,
  output logic [CODE_W-1:0]      code,
  output logic                   bubble
);

  always_comb begin
    code   = '0;
    bubble = 1'b0;
    for (int i = 0; i < PHASE_WIDTH; i++) begin
      code = code + CODE_W'(sample[i]);
    end
    // A set bit sitting above a clear bit breaks the thermometer pattern.
    for (int i = 1; i < PHASE_WIDTH; i++) begin
      if (sample[i] && !sample[i-1]) bubble = 1'b1;
    end
  end

endmodule

// File: rtl/phase_readout_ctrl.sv
// Measurement sequencer: settle, sample 2^L phase vectors, accumulate their
// thermometer counts and hand back a fixed-point average over valid/ready.
module phase_readout_ctrl
  import phase_readout_pkg::*;
#(
  parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
  parameter int CODE_W       = DEF_CODE_W,
  parameter int AVG_MAX_LOG2 = DEF_AVG_MAX_LOG2,
  parameter int ACC_W        = CODE_W + AVG_MAX_LOG2,
  parameter int SETTLE_W     = DEF_SETTLE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [SETTLE_W-1:0]    settle_cfg_i,
  input  logic [2:0]             avg_log2_i,
  input  logic [PHASE_WIDTH-1:0] phase_i,
  output logic                   enable_o,
  output logic                   busy_o,
  output logic [ACC_W-1:0]       result_o,
  output logic                   bubble_err_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int SMP_W = (AVG_MAX_LOG2 > 0) ? AVG_MAX_LOG2 : 1;

  state_t                 state;
  state_t                 state_nx;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic [SMP_W-1:0]       smp_cnt;
  logic [2:0]             avg_l;
  logic [2:0]             avg_clamped;

  logic [PHASE_WIDTH-1:0] sample_p0;
  logic                   vld_p0;
  logic [CODE_W-1:0]      code_p0;
  logic                   bubble_p0;

  logic [ACC_W-1:0]       acc_p1;
  logic                   bubble_p1;
  logic [ACC_W-1:0]       acc_sum;
  logic                   bubble_sum;

  assign avg_clamped = (avg_log2_i > 3'(AVG_MAX_LOG2)) ? 3'(AVG_MAX_LOG2) : avg_log2_i;

  phase_therm_enc #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .CODE_W      (CODE_W)
  ) u_enc (
    .sample (sample_p0),
    .code   (code_p0),
    .bubble (bubble_p0)
  );

  assign acc_sum    = acc_p1 + (vld_p0 ? ACC_W'(code_p0) : '0);
  assign bubble_sum = bubble_p1 | (vld_p0 & bubble_p0);

  always_comb begin
    state_nx = state;
    if (abort_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_nx = SETTLE;
        SETTLE:  if (settle_cnt == '0) state_nx = SAMPLE;
        SAMPLE:  if (smp_cnt == '0) state_nx = DRAIN;
        DRAIN:   state_nx = DONE;
        DONE:    if (ready_i) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      enable_o     <= 1'b0;
      busy_o       <= 1'b0;
      valid_o      <= 1'b0;
      result_o     <= '0;
      bubble_err_o <= 1'b0;
      settle_cnt   <= '0;
      smp_cnt      <= '0;
      avg_l        <= '0;
      sample_p0    <= '0;
      vld_p0       <= 1'b0;
      acc_p1       <= '0;
      bubble_p1    <= 1'b0;
    end else begin
      state    <= state_nx;
      enable_o <= (state_nx == SETTLE) || (state_nx == SAMPLE);
      busy_o   <= (state_nx != IDLE);
      valid_o  <= (state_nx == DONE);

      // Stage p0: capture the phase vector while sampling.
      vld_p0 <= (state == SAMPLE) && !abort_i;
      if (state == SAMPLE) sample_p0 <= phase_i;

      // Stage p1: fold the encoded count of the previous capture in.
      acc_p1    <= acc_sum;
      bubble_p1 <= bubble_sum;

      case (state)
        IDLE: begin
          if (start_i && !abort_i) begin
            settle_cnt <= settle_cfg_i;
            avg_l      <= avg_clamped;
            acc_p1     <= '0;
            bubble_p1  <= 1'b0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == '0) smp_cnt <= SMP_W'((1 << avg_l) - 1);
        end
        SAMPLE: begin
          smp_cnt <= smp_cnt - 1'b1;
        end
        DRAIN: begin
          // Scale to AVG_MAX_LOG2 fractional bits so the format is fixed.
          if (!abort_i) begin
            result_o     <= acc_sum << (3'(AVG_MAX_LOG2) - avg_l);
            bubble_err_o <= bubble_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_readout_ctrl.sv
// Randomized self-checking bench for phase_readout_ctrl against a counting model.
module tb_phase_readout_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i, ready_i;
  logic [7:0]  settle_cfg_i;
  logic [2:0]  avg_log2_i;
  logic [10:0] phase_i;
  logic        enable_o, busy_o, bubble_err_o, valid_o;
  logic [7:0]  result_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] smp_tab [16];
  logic [7:0]  last_res;

  always #5 clk = ~clk;

  phase_readout_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .settle_cfg_i (settle_cfg_i),
    .avg_log2_i   (avg_log2_i),
    .phase_i      (phase_i),
    .enable_o     (enable_o),
    .busy_o       (busy_o),
    .result_o     (result_o),
    .bubble_err_o (bubble_err_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
  );

  function automatic int eff_l(input int avg);
    return (avg > 4) ? 4 : avg;
  endfunction

  function automatic int popc(input logic [10:0] v);
    int c = 0;
    for (int i = 0; i < 11; i++) c += int'(v[i]);
    return c;
  endfunction

  // Clean thermometer codes are exactly 2^k - 1.
  function automatic bit is_therm(input logic [10:0] v);
    int x = int'(v);
    return ((x & (x + 1)) == 0);
  endfunction

  function automatic int model_res(input int avg);
    int l = eff_l(avg);
    int sum = 0;
    for (int j = 0; j < (1 << l); j++) sum += popc(smp_tab[j]);
    return sum * (1 << (4 - l));
  endfunction

  function automatic bit model_bub(input int avg);
    bit b = 0;
    for (int j = 0; j < (1 << eff_l(avg)); j++) if (!is_therm(smp_tab[j])) b = 1;
    return b;
  endfunction

  // Drives one measurement with ready held high; observes at negedges after E0.
  task automatic run_meas(input int s, input int avg, output int vld_at, output int en_cnt,
                          output logic [7:0] res, output logic bub,
                          output logic post_vld, output logic post_busy);
    int n = 1 << eff_l(avg);
    int j;
    vld_at = -1; en_cnt = 0; res = '0; bub = 1'b0;
    @(negedge clk);
    settle_cfg_i = 8'(s); avg_log2_i = 3'(avg); start_i = 1'b1; ready_i = 1'b1;
    phase_i = 11'($urandom);
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 0; k < s + n + 40 && vld_at < 0; k++) begin
      if (enable_o) en_cnt++;
      if (valid_o) begin vld_at = k; res = result_o; bub = bubble_err_o; end
      j = k - s - 1;
      phase_i = (j >= 0 && j < n) ? smp_tab[j] : 11'($urandom);
      @(negedge clk);
    end
    post_vld = valid_o; post_busy = busy_o;
  endtask

  task automatic test_reset_initial();
    rst_n = 1'b0; start_i = 0; abort_i = 0; ready_i = 0;
    settle_cfg_i = 0; avg_log2_i = 0; phase_i = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({enable_o, busy_o, valid_o, bubble_err_o, result_o} !== 12'h000) begin
      n_fail++; $display("FAIL reset_init: outputs=%h expected 000", {enable_o, busy_o, valid_o, bubble_err_o, result_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int va, en; logic [7:0] r; logic b, pv, pb;
    smp_tab[0] = 11'h01F;
    run_meas(2, 0, va, en, r, b, pv, pb);
    n_checks++; if (va !== 5) begin n_fail++; $display("FAIL single_latency: got %0d expected 5", va); end
    n_checks++; if (en !== 4) begin n_fail++; $display("FAIL single_enable: got %0d expected 4", en); end
    n_checks++; if (r !== 8'h50) begin n_fail++; $display("FAIL single_result: got %h expected 50", r); end
    n_checks++; if (b !== 1'b0) begin n_fail++; $display("FAIL single_bubble: got %b expected 0", b); end
    n_checks++; if ({pv, pb} !== 2'b00) begin n_fail++; $display("FAIL single_release: valid,busy=%b%b expected 00", pv, pb); end
    last_res = r;
  endtask

  task automatic test_averaging();
    int va, en; logic [7:0] r; logic b, pv, pb;
    smp_tab[0] = 11'h007; smp_tab[1] = 11'h00F; smp_tab[2] = 11'h00F; smp_tab[3] = 11'h01F;
    run_meas(1, 2, va, en, r, b, pv, pb);
    n_checks++; if (r !== 8'h40) begin n_fail++; $display("FAIL avg4_result: got %h expected 40", r); end
    n_checks++; if (va !== 1 + 4 + 2) begin n_fail++; $display("FAIL avg4_latency: got %0d expected 7", va); end
    for (int i = 0; i < 16; i++) smp_tab[i] = 11'h7FF;
    run_meas(0, 7, va, en, r, b, pv, pb);
    n_checks++; if (r !== 8'hB0) begin n_fail++; $display("FAIL clamp_result: got %h expected b0", r); end
    n_checks++; if (va !== 18) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 18", va); end
    n_checks++; if (en !== 17) begin n_fail++; $display("FAIL settle0_enable: got %0d expected 17", en); end
    last_res = r;
  endtask

  task automatic test_bubble();
    int va, en; logic [7:0] r; logic b, pv, pb;
    smp_tab[0] = 11'h005; smp_tab[1] = 11'h003;
    run_meas(1, 1, va, en, r, b, pv, pb);
    n_checks++; if (r !== 8'h20) begin n_fail++; $display("FAIL bubble_result: got %h expected 20", r); end
    n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL bubble_flag: got %b expected 1", b); end
    smp_tab[0] = 11'h003;
    run_meas(1, 1, va, en, r, b, pv, pb);
    n_checks++; if (b !== 1'b0) begin n_fail++; $display("FAIL bubble_clear: got %b expected 0", b); end
    n_checks++; if (r !== 8'h20) begin n_fail++; $display("FAIL clean_result: got %h expected 20", r); end
    last_res = r;
  endtask

  task automatic test_backpressure();
    int k = 0;
    @(negedge clk);
    settle_cfg_i = 8'd1; avg_log2_i = 3'd0; phase_i = 11'h003; ready_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (!valid_o && k < 50) begin @(negedge clk); k++; end
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: valid=%b expected 1", valid_o); end
    for (int i = 0; i < 10; i++) begin
      start_i = i[0];
      settle_cfg_i = 8'(i); phase_i = 11'h7FF;
      @(negedge clk);
      n_checks++;
      if ({valid_o, result_o} !== {1'b1, 8'h20}) begin
        n_fail++; $display("FAIL bp_hold: valid,result=%b,%h expected 1,20", valid_o, result_o);
      end
    end
    ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n_checks++; if ({valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL bp_handshake: valid,busy=%b%b expected 00", valid_o, busy_o); end
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored: busy=%b expected 0", busy_o); end
    last_res = 8'h20;
  endtask

  task automatic test_abort();
    int va, en, vcnt; logic [7:0] r; logic b, pv, pb;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      settle_cfg_i = (pass == 0) ? 8'd3 : 8'd0; avg_log2_i = 3'd2; phase_i = 11'h7FF; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat ((pass == 0) ? 1 : 3) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      n_checks++;
      if ({busy_o, enable_o, valid_o} !== 3'b000) begin
        n_fail++; $display("FAIL abort_%0d_state: busy,en,valid=%b%b%b expected 000", pass, busy_o, enable_o, valid_o);
      end
      n_checks++; if (result_o !== last_res) begin n_fail++; $display("FAIL abort_%0d_result: got %h expected %h", pass, result_o, last_res); end
      vcnt = 0;
      repeat (6) begin @(negedge clk); vcnt += int'(valid_o); end
      n_checks++; if (vcnt !== 0) begin n_fail++; $display("FAIL abort_%0d_novalid: got %0d valid cycles expected 0", pass, vcnt); end
    end
    for (int i = 0; i < 4; i++) smp_tab[i] = 11'h001;
    run_meas(2, 2, va, en, r, b, pv, pb);
    n_checks++; if (r !== 8'h10) begin n_fail++; $display("FAIL abort_restart: got %h expected 10", r); end
    last_res = r;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    settle_cfg_i = 8'd1; avg_log2_i = 3'd2; phase_i = 11'h7FF; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({enable_o, busy_o, valid_o, bubble_err_o, result_o} !== 12'h000) begin
      n_fail++; $display("FAIL reset_mid: outputs=%h expected 000", {enable_o, busy_o, valid_o, bubble_err_o, result_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if ({busy_o, enable_o} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: busy,en=%b%b expected 00", busy_o, enable_o); end
  endtask

  task automatic test_random();
    int va, en, s, avg, n; logic [7:0] r; logic b, pv, pb;
    for (int it = 0; it < 20; it++) begin
      s = $urandom_range(0, 5); avg = $urandom_range(0, 7); n = 1 << eff_l(avg);
      for (int j = 0; j < 16; j++)
        smp_tab[j] = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'((1 << $urandom_range(0, 11)) - 1);
      run_meas(s, avg, va, en, r, b, pv, pb);
      n_checks++;
      if (r !== 8'(model_res(avg)) || b !== model_bub(avg)) begin
        n_fail++; $display("FAIL rand_%0d_result: got %h/%b expected %h/%b", it, r, b, 8'(model_res(avg)), model_bub(avg));
      end
      n_checks++;
      if (va !== s + n + 2 || en !== s + n + 1) begin
        n_fail++; $display("FAIL rand_%0d_timing: latency %0d enable %0d expected %0d %0d", it, va, en, s + n + 2, s + n + 1);
      end
    end
  endtask

  initial begin
    test_reset_initial();
    test_single();
    test_averaging();
    test_bubble();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
